irq_aggr: RTL and testbench

IRQ_AGGR -- requirements
Module: irq_aggr

---
 rtl/irq_pkg.sv | 17 +
 rtl/irq_aggr_if.sv | 29 ++
 rtl/irq_prio_enc.sv | 22 ++
 rtl/irq_aggr.sv | 98 +++++++++
 tb/tb_irq_aggr.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt aggregator.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } irq_state_e;

  localparam int unsigned IRQ_CNT_W = 16;

  // Index width for a given source count, never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_aggr_if.sv
// Status/acknowledge bundle between the interrupt consumer and irq_aggr.
// irq_cnt exists only when IRQ_AGGR_CNT_EN is defined.
interface irq_aggr_if #(
  parameter int unsigned N_SRC  = 8,
  parameter int unsigned HOLD_W = 8
);
  localparam int unsigned ID_W = irq_pkg::id_width(N_SRC);

  logic [N_SRC-1:0]  status;
  logic [N_SRC-1:0]  mask_en;
  logic [HOLD_W-1:0] holdoff;
  logic              irq_ack;
  logic              irq;
  logic [ID_W-1:0]   irq_id;
`ifdef IRQ_AGGR_CNT_EN
  logic [irq_pkg::IRQ_CNT_W-1:0] irq_cnt;

  modport master (output status, mask_en, holdoff, irq_ack,
                  input  irq, irq_id, irq_cnt);
  modport slave  (input  status, mask_en, holdoff, irq_ack,
                  output irq, irq_id, irq_cnt);
`else
  modport master (output status, mask_en, holdoff, irq_ack,
                  input  irq, irq_id);
  modport slave  (input  status, mask_en, holdoff, irq_ack,
                  output irq, irq_id);
`endif

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the active source vector.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter  int unsigned N_SRC = 8,
  localparam int unsigned ID_W  = id_width(N_SRC)
) (
  input  logic [N_SRC-1:0] req_i,
  output logic [ID_W-1:0]  idx_o_c,
  output logic             any_o_c
);

  // Scan from the top so the lowest set index is written last.
  always_comb begin
    idx_o_c = '0;
    any_o_c = |req_i;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o_c = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_aggr.sv
// Interrupt aggregator: ORs masked sticky status into one level irq with
// a captured source id and a post-acknowledge hold-off. IRQ_AGGR_CNT_EN adds irq_cnt.
module irq_aggr
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC  = 8,
  parameter int unsigned HOLD_W = 8
) (
  input logic       clk,
  input logic       rst_n,
  irq_aggr_if.slave bus
);

  localparam int unsigned ID_W = id_width(N_SRC);

  irq_state_e        state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              irq_q, irq_d;
  logic [ID_W-1:0]   cand_id_c;
  logic              pend_c;

  irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
    .req_i   (bus.status & bus.mask_en),
    .idx_o_c (cand_id_c),
    .any_o_c (pend_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      irq_q   <= irq_d;
    end
  end

  // Acknowledge wins over a simultaneous drop of pend.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (pend_c) begin
          state_d = ASSERT;
          id_d    = cand_id_c;
        end
      end
      ASSERT: begin
        if (bus.irq_ack) begin
          if (bus.holdoff == '0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            cnt_d   = bus.holdoff;
          end
        end else if (!pend_c) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        cnt_d = cnt_q - HOLD_W'(1);
        if (cnt_q == HOLD_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    irq_d = (state_d == ASSERT);
  end

  assign bus.irq    = irq_q;
  assign bus.irq_id = id_q;

`ifdef IRQ_AGGR_CNT_EN
  logic [IRQ_CNT_W-1:0] irq_cnt_q, irq_cnt_d;
  logic                 rise_c;

  // Saturating count of IDLE->ASSERT transitions.
  always_comb begin
    rise_c    = (state_q == IDLE) && (state_d == ASSERT);
    irq_cnt_d = irq_cnt_q;
    if (rise_c && (irq_cnt_q != '1)) irq_cnt_d = irq_cnt_q + IRQ_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_cnt_q <= '0;
    else        irq_cnt_q <= irq_cnt_d;
  end

  assign bus.irq_cnt = irq_cnt_q;
`endif

endmodule

// File: tb/tb_irq_aggr.sv
// Self-checking bench for irq_aggr: vector table plus hold-off/reset sequences.
module tb_irq_aggr;
  import irq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  irq_aggr_if #(.N_SRC(8), .HOLD_W(8)) bus ();

  irq_aggr #(.N_SRC(8), .HOLD_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] st;
    logic [7:0] mk;
    logic       irq;
    logic [2:0] id;
  } vec_t;

  vec_t vecs [10];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic e_irq, input logic [2:0] e_id);
    chk({name, ".irq"}, 32'(bus.irq), 32'(e_irq));
    chk({name, ".id"},  32'(bus.irq_id), 32'(e_id));
  endtask

  initial begin
    // irq_id is only captured on entry to ASSERT, so idle rows keep the prior id.
    vecs[0] = '{8'h24, 8'hFF, 1'b1, 3'd2};
    vecs[1] = '{8'h80, 8'h7F, 1'b0, 3'd2};
    vecs[2] = '{8'h80, 8'hFF, 1'b1, 3'd7};
    vecs[3] = '{8'h01, 8'h01, 1'b1, 3'd0};
    vecs[4] = '{8'hFF, 8'h00, 1'b0, 3'd0};
    vecs[5] = '{8'hF0, 8'h30, 1'b1, 3'd4};
    vecs[6] = '{8'h0A, 8'h0C, 1'b1, 3'd3};
    vecs[7] = '{8'h00, 8'hFF, 1'b0, 3'd3};
    vecs[8] = '{8'h81, 8'hFE, 1'b1, 3'd7};
    vecs[9] = '{8'hFF, 8'hFF, 1'b1, 3'd0};

    rst_n       = 1'b0;
    bus.status  = '0;
    bus.mask_en = '0;
    bus.holdoff = 8'd3;
    bus.irq_ack = 1'b0;
    #12;
    chk_out("reset", 1'b0, 3'd0);
    chk("reset.state", 32'(dut.state_q), 32'(IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      bus.status  = vecs[i].st;
      bus.mask_en = vecs[i].mk;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].irq, vecs[i].id);
      bus.status = '0;
      tick();
      chk($sformatf("vec%0d.clr", i), 32'(bus.irq), 32'(0));
    end

    // Capture id 2, then prove it holds while a higher index is the only source.
    bus.mask_en = 8'hFF;
    bus.status  = 8'h24;
    tick();
    chk_out("a.rise", 1'b1, 3'd2);
    bus.status = 8'h20;
    tick();
    chk_out("a.idhold", 1'b1, 3'd2);
    bus.status = 8'h24;

    // holdoff=3: three HOLD cycles, one IDLE cycle, then re-assert.
    bus.holdoff = 8'd3;
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    chk("h.c1", 32'(bus.irq), 32'(0));
    chk("h.c1.state", 32'(dut.state_q), 32'(HOLD));
    bus.holdoff = 8'd7;
    bus.status  = 8'h20;
    tick();
    chk_out("h.c2", 1'b0, 3'd2);
    bus.irq_ack = 1'b1;
    bus.status  = 8'h24;
    tick();
    bus.irq_ack = 1'b0;
    chk("h.c3", 32'(bus.irq), 32'(0));
    chk("h.c3.state", 32'(dut.state_q), 32'(HOLD));
    tick();
    chk("h.idle", 32'(bus.irq), 32'(0));
    chk("h.idle.state", 32'(dut.state_q), 32'(IDLE));
    tick();
    chk_out("h.reassert", 1'b1, 3'd2);

    // holdoff=0: acknowledge returns straight to IDLE.
    bus.holdoff = 8'd0;
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    chk("z.ack", 32'(bus.irq), 32'(0));
    chk("z.ack.state", 32'(dut.state_q), 32'(IDLE));
    tick();
    chk("z.reassert", 32'(bus.irq), 32'(1));

    // Sources drop with no acknowledge.
    bus.status = '0;
    tick();
    chk("d.irq", 32'(bus.irq), 32'(0));
    chk("d.state", 32'(dut.state_q), 32'(IDLE));

    // Acknowledge and pend drop together: acknowledge rule wins.
    bus.status = 8'h24;
    tick();
    chk("b.rise", 32'(bus.irq), 32'(1));
    bus.holdoff = 8'd2;
    bus.status  = '0;
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    chk("b.state", 32'(dut.state_q), 32'(HOLD));
    bus.status = 8'h24;
    tick();
    chk("b.hold2", 32'(bus.irq), 32'(0));
    tick();
    chk("b.idle", 32'(bus.irq), 32'(0));
    tick();
    chk("b.reassert", 32'(bus.irq), 32'(1));

    // Reset mid-HOLD clears the captured id asynchronously.
    bus.holdoff = 8'd5;
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk_out("r.hold", 1'b0, 3'd0);
    chk("r.hold.state", 32'(dut.state_q), 32'(IDLE));
    tick();
    chk("r.held", 32'(bus.irq), 32'(0));
    rst_n = 1'b1;
    tick();
    chk_out("r.release", 1'b1, 3'd2);

    // Reset mid-ASSERT drops irq without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk_out("r.assert", 1'b0, 3'd0);
    rst_n = 1'b1;
    tick();
    chk_out("r.release2", 1'b1, 3'd2);

`ifdef IRQ_AGGR_CNT_EN
    bus.status = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("c.reset", 32'(bus.irq_cnt), 32'(0));
    rst_n       = 1'b1;
    bus.holdoff = 8'd0;
    for (int k = 0; k < 5; k++) begin
      bus.status = 8'h24;
      tick();
      bus.irq_ack = 1'b1;
      tick();
      bus.irq_ack = 1'b0;
      bus.status  = '0;
      tick();
    end
    chk("c.five", 32'(bus.irq_cnt), 32'(5));
    force dut.irq_cnt_q = 16'hFFFE;
    #1 release dut.irq_cnt_q;
    for (int k = 0; k < 2; k++) begin
      bus.status = 8'h24;
      tick();
      bus.irq_ack = 1'b1;
      tick();
      bus.irq_ack = 1'b0;
      bus.status  = '0;
      tick();
    end
    chk("c.sat", 32'(bus.irq_cnt), 32'(16'hFFFF));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
